// File: rtl/instruction_fetch.sv
// Fetch stage: issues one read at a time at pc, buffers returned words with their
// addresses in a small FIFO and presents them to the decoder over valid/ready.
module instruction_fetch #(
  parameter int addr_size = 16,
  parameter int data_size = 16,
  parameter int depth     = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [addr_size-1:0] pc,
  output logic                 pc_incr,
  input  logic                 flush,
  output logic                 mem_req,
  output logic [addr_size-1:0] mem_addr,
  input  logic                 mem_gnt,
  input  logic                 mem_rvalid,
  input  logic [data_size-1:0] mem_rdata,
  output logic                 inst_valid,
  output logic [data_size-1:0] inst_data,
  output logic [addr_size-1:0] inst_addr,
  input  logic                 inst_ready
);

  localparam int PW = $clog2(depth);
  localparam int CW = PW + 1;
  localparam logic [CW:0] DEPTH_L = (CW + 1)'(depth);

  typedef enum logic [1:0] {
    REQ  = 2'd0,
    WAIT = 2'd1,
    DROP = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [CW-1:0]        count_q, count_d;
  logic [PW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]        rd_ptr_q, rd_ptr_d;
  logic [addr_size-1:0] pend_addr_q, pend_addr_d;
  logic [addr_size-1:0] addr_mem_q [depth];
  logic [data_size-1:0] data_mem_q [depth];

  logic        space;
  logic        grant;
  logic        push;
  logic        pop;
  logic [CW:0] used;

  // An outstanding read already owns a FIFO slot, so overflow is impossible.
  assign used  = {1'b0, count_q} + {{CW{1'b0}}, (state_q != REQ)};
  assign space = used < DEPTH_L;

  assign mem_req  = (state_q == REQ) & space & ~flush & ~rst;
  assign mem_addr = pc;
  assign grant    = mem_req & mem_gnt;
  assign pc_incr  = grant;

  assign inst_valid = (count_q != '0);
  assign inst_data  = data_mem_q[rd_ptr_q];
  assign inst_addr  = addr_mem_q[rd_ptr_q];

  assign push = (state_q == WAIT) & mem_rvalid & ~flush;
  assign pop  = inst_valid & inst_ready & ~flush;

  always_comb begin
    state_d     = state_q;
    pend_addr_d = pend_addr_q;
    unique case (state_q)
      REQ: begin
        if (grant) begin
          pend_addr_d = pc;
          state_d     = WAIT;
        end
      end
      WAIT: begin
        if (mem_rvalid) begin
          state_d = REQ;
        end else if (flush) begin
          state_d = DROP;
        end
      end
      DROP: begin
        // The read issued before the jump still has to drain.
        if (mem_rvalid) begin
          state_d = REQ;
        end
      end
      default: state_d = REQ;
    endcase
  end

  always_comb begin
    count_d  = count_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush) begin
      count_d  = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + PW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
      unique case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= REQ;
      count_q     <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      pend_addr_q <= '0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      pend_addr_q <= pend_addr_d;
    end
  end

  // Storage needs no reset: entries are only read when count_q says they are valid.
  always_ff @(posedge clk) begin
    if (push) begin
      addr_mem_q[wr_ptr_q] <= pend_addr_q;
      data_mem_q[wr_ptr_q] <= mem_rdata;
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: an instruction-pointer and memory responder around the
// DUT, with a queue-based model of the decoder stream compared every cycle.
module tb_instruction_fetch;

  localparam int DEPTH = 2;

  typedef struct packed {
    logic [15:0] a;
    logic [15:0] d;
  } ent_t;

  logic        clk;
  logic        rst;
  logic [15:0] pc;
  logic        pc_incr;
  logic        flush;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [15:0] mem_rdata;
  logic        inst_valid;
  logic [15:0] inst_data;
  logic [15:0] inst_addr;
  logic        inst_ready;

  instruction_fetch #(.addr_size(16), .data_size(16), .depth(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .pc         (pc),
    .pc_incr    (pc_incr),
    .flush      (flush),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_gnt    (mem_gnt),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata),
    .inst_valid (inst_valid),
    .inst_data  (inst_data),
    .inst_addr  (inst_addr),
    .inst_ready (inst_ready)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // memory responder and instruction pointer state
  bit          mbusy = 0;
  int          mwait = 0;
  logic [15:0] maddr = '0;
  logic [15:0] key = 16'hA5A5;
  int          gnt_pct = 100;
  int          lat_lo = 1;
  int          lat_hi = 1;
  logic        prev_incr = 0;
  logic        prev_flush = 0;
  logic [15:0] prev_jt = '0;
  int          incr_cnt = 0;

  // scoreboard: expected FIFO contents, in-flight fetch, decoder log
  ent_t        exp_q[$];
  ent_t        got_q[$];
  bit          infl = 0;
  bit          infl_dead = 0;
  logic [15:0] infl_addr = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model of one cycle: what the outputs must be, then the events at the next edge.
  task automatic compare_cycle();
    bit   exp_req;
    ent_t e;
    if (rst) begin
      exp_q.delete();
      infl      = 0;
      infl_dead = 0;
      check("rst_inst_valid", 32'(inst_valid), 32'(0));
      check("rst_mem_req", 32'(mem_req), 32'(0));
      check("rst_pc_incr", 32'(pc_incr), 32'(0));
      return;
    end
    exp_req = !infl && (exp_q.size() < DEPTH) && !flush;
    check("mem_req", 32'(mem_req), 32'(exp_req));
    check("pc_incr", 32'(pc_incr), 32'(exp_req && mem_gnt));
    if (exp_req) check("mem_addr", 32'(mem_addr), 32'(pc));
    check("inst_valid", 32'(inst_valid), 32'(exp_q.size() != 0));
    if (exp_q.size() != 0) begin
      check("inst_addr", 32'(inst_addr), 32'(exp_q[0].a));
      check("inst_data", 32'(inst_data), 32'(exp_q[0].d));
    end
    if (flush) begin
      exp_q.delete();
      if (infl) begin
        if (mem_rvalid) infl = 0;
        else infl_dead = 1;
      end
    end else begin
      if (exp_q.size() != 0 && inst_ready) got_q.push_back(exp_q.pop_front());
      if (infl && mem_rvalid) begin
        if (!infl_dead) begin
          e = {infl_addr, mem_rdata};
          exp_q.push_back(e);
        end
        infl = 0;
      end
    end
    if (exp_req && mem_gnt) begin
      infl      = 1;
      infl_dead = 0;
      infl_addr = pc;
    end
  endtask

  // driver: one clock cycle of pointer, memory and decoder stimulus
  task automatic step(input logic r, input logic fl, input logic [15:0] jt, input logic rdy);
    @(posedge clk);
    #1;
    rst = r;
    if (r) begin
      pc         = '0;
      prev_incr  = 0;
      prev_flush = 0;
    end else if (prev_flush) begin
      pc = prev_jt;
    end else if (prev_incr) begin
      pc = pc + 16'd1;
    end
    flush      = fl;
    inst_ready = rdy;
    mem_rvalid = 1'b0;
    mem_rdata  = 16'($urandom);
    if (mbusy) begin
      mwait--;
      if (mwait == 0) begin
        mem_rvalid = 1'b1;
        mem_rdata  = maddr ^ key;
        mbusy      = 0;
      end
    end
    mem_gnt = !mbusy && ($urandom_range(0, 99) < gnt_pct);
    @(negedge clk);
    compare_cycle();
    if (pc_incr) incr_cnt++;
    if (mem_req && mem_gnt) begin
      mbusy = 1;
      mwait = int'($urandom_range(lat_lo, lat_hi));
      maddr = pc;
    end
    prev_incr  = pc_incr;
    prev_flush = fl;
    prev_jt    = jt;
  endtask

  task automatic do_reset(input bit clear_mem);
    if (clear_mem) mbusy = 0;
    step(1'b1, 1'b0, 16'h0, 1'b0);
    step(1'b1, 1'b0, 16'h0, 1'b0);
    got_q.delete();
    incr_cnt = 0;
  endtask

  initial begin
    bit seen_dead;
    rst = 1'b1; pc = '0; flush = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b0;
    mem_rdata = '0; inst_ready = 1'b0;

    // free-run
    key = 16'hA5A5; gnt_pct = 100; lat_lo = 1; lat_hi = 1;
    do_reset(1);
    for (int c = 0; c < 20; c++) step(1'b0, 1'b0, 16'h0, 1'b1);
    check("free_incr_count", 32'(incr_cnt), 32'd10);
    check("free_got_count", 32'(got_q.size()), 32'd9);
    if (got_q.size() >= 9) begin
      check("free_got0", 32'(got_q[0]), 32'h0000_A5A5);
      check("free_got1", 32'(got_q[1]), 32'h0001_A5A4);
      check("free_got8", 32'(got_q[8]), 32'h0008_A5AD);
    end

    // backpressure
    do_reset(1);
    for (int c = 0; c < 12; c++) step(1'b0, 1'b0, 16'h0, 1'b0);
    check("bp_grants", 32'(incr_cnt), 32'd2);
    check("bp_mem_req", 32'(mem_req), 32'd0);
    check("bp_inst_valid", 32'(inst_valid), 32'd1);
    check("bp_inst_addr", 32'(inst_addr), 32'h0000);
    for (int c = 0; c < 20; c++) step(1'b0, 1'b0, 16'h0, 1'b1);
    check("bp_resume_count", 32'(got_q.size() >= 3), 32'd1);
    if (got_q.size() >= 3) begin
      check("bp_order0", 32'(got_q[0].a), 32'h0000);
      check("bp_order1", 32'(got_q[1].a), 32'h0001);
      check("bp_order2", 32'(got_q[2].a), 32'h0002);
    end

    // flush during WAIT: read at 0x0010 returns 0xDEAD after the jump
    key = 16'hDEBD; lat_lo = 4; lat_hi = 4;
    do_reset(1);
    step(1'b0, 1'b1, 16'h0010, 1'b1);
    step(1'b0, 1'b0, 16'h0, 1'b1);
    check("fw_grant_addr", 32'(maddr), 32'h0010);
    lat_lo = 1; lat_hi = 1;
    step(1'b0, 1'b1, 16'h0100, 1'b1);
    step(1'b0, 1'b0, 16'h0, 1'b1);
    check("fw_req_c3", 32'(mem_req), 32'd0);
    step(1'b0, 1'b0, 16'h0, 1'b1);
    check("fw_req_c4", 32'(mem_req), 32'd0);
    step(1'b0, 1'b0, 16'h0, 1'b1);
    check("fw_req_c5", 32'(mem_req), 32'd0);
    step(1'b0, 1'b0, 16'h0, 1'b1);
    check("fw_req_c6", 32'(mem_req), 32'd1);
    check("fw_addr_c6", 32'(mem_addr), 32'h0100);
    for (int c = 0; c < 10; c++) step(1'b0, 1'b0, 16'h0, 1'b1);
    seen_dead = 0;
    foreach (got_q[i]) if (got_q[i].d == 16'hDEAD) seen_dead = 1;
    check("fw_no_dead", 32'(seen_dead), 32'd0);
    if (got_q.size() != 0) check("fw_first_addr", 32'(got_q[0].a), 32'h0100);
    else check("fw_got_any", 32'(got_q.size()), 32'd1);

    // flush coincident with rvalid, one entry buffered
    key = 16'hA5A5; lat_lo = 3; lat_hi = 3;
    do_reset(1);
    for (int c = 0; c < 7; c++) step(1'b0, 1'b0, 16'h0, 1'b0);
    check("fc_valid_c6", 32'(inst_valid), 32'd1);
    step(1'b0, 1'b1, 16'h0200, 1'b1);
    check("fc_rvalid_c7", 32'(mem_rvalid), 32'd1);
    check("fc_no_pop", 32'(got_q.size()), 32'd0);
    step(1'b0, 1'b0, 16'h0, 1'b1);
    check("fc_valid_c8", 32'(inst_valid), 32'd0);
    check("fc_req_c8", 32'(mem_req), 32'd1);
    check("fc_addr_c8", 32'(mem_addr), 32'h0200);
    for (int c = 0; c < 10; c++) step(1'b0, 1'b0, 16'h0, 1'b1);

    // reset while WAIT with one entry buffered; stale rvalid after release
    lat_lo = 2; lat_hi = 2;
    do_reset(1);
    for (int c = 0; c < 3; c++) step(1'b0, 1'b0, 16'h0, 1'b0);
    lat_lo = 6; lat_hi = 6;
    step(1'b0, 1'b0, 16'h0, 1'b0);
    lat_lo = 1; lat_hi = 1;
    step(1'b0, 1'b0, 16'h0, 1'b0);
    check("rs_valid_before", 32'(inst_valid), 32'd1);
    rst = 1'b1;
    #1;
    check("rs_valid_now", 32'(inst_valid), 32'd0);
    check("rs_req_now", 32'(mem_req), 32'd0);
    check("rs_incr_now", 32'(pc_incr), 32'd0);
    do_reset(0);
    step(1'b0, 1'b0, 16'h0, 1'b1);
    step(1'b0, 1'b0, 16'h0, 1'b1);
    check("rs_req_held", 32'(mem_req), 32'd1);
    check("rs_addr_held", 32'(mem_addr), 32'h0000);
    for (int c = 0; c < 15; c++) step(1'b0, 1'b0, 16'h0, 1'b1);
    if (got_q.size() != 0) check("rs_first", 32'(got_q[0]), 32'h0000_A5A5);
    else check("rs_got_any", 32'(got_q.size()), 32'd1);

    // wrap past 0xFFFF
    key = 16'h1234;
    do_reset(1);
    step(1'b0, 1'b1, 16'hFFFF, 1'b1);
    for (int c = 0; c < 12; c++) step(1'b0, 1'b0, 16'h0, 1'b1);
    if (got_q.size() >= 2) begin
      check("wrap0", 32'(got_q[0]), 32'hFFFF_EDCB);
      check("wrap1", 32'(got_q[1]), 32'h0000_1234);
    end else begin
      check("wrap_count", 32'(got_q.size()), 32'd2);
    end

    // randomized traffic
    key = 16'($urandom); gnt_pct = 60; lat_lo = 1; lat_hi = 4;
    do_reset(1);
    for (int c = 0; c < 4000; c++) begin
      step(1'b0, ($urandom_range(0, 99) < 4), 16'($urandom), ($urandom_range(0, 99) < 70));
    end
    check("rand_progress", 32'(got_q.size() > 100), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
